nibble_serial_add_arbiter: RTL and testbench

Shares one 4-bit ripple-carry add slice between two requesters and performs multi-nibble additions over it. Each accepted operation adds two W-bit operands, W = 4·NIBBLES, one nibble per clock, LSB nibble first, with the carry held in a register between nibbles. The block sits in front of the accumulation stages of the recognition datapath. It replaces wide parallel adders where area matters more than throughput.

---
 rtl/nibble_serial_add_arbiter.sv | 153 +++++++++++++++
 tb/tb_nibble_serial_add_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_arbiter.sv
// Two-requester round-robin front end sharing one 4-bit add slice.
// Each accepted operation adds two W-bit operands one nibble per clock, LSB first.
module nibble_serial_add_arbiter #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req0,
   input  logic                 i_req1,
   input  logic [4*NIBBLES-1:0] i_a0,
   input  logic [4*NIBBLES-1:0] i_b0,
   input  logic [4*NIBBLES-1:0] i_a1,
   input  logic [4*NIBBLES-1:0] i_b1,
   input  logic                 i_cin0,
   input  logic                 i_cin1,
   output logic                 o_gnt0,
   output logic                 o_gnt1,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_done_id,
   output logic [4*NIBBLES-1:0] o_sum,
   output logic                 o_cout
);

   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state, w_state_n;
   logic [W-1:0]    r_a, w_a_n;
   logic [W-1:0]    r_b, w_b_n;
   logic [W-1:0]    r_res, w_res_n;
   logic [W-1:0]    r_sum, w_sum_n;
   logic [IW-1:0]   r_idx, w_idx_n;
   logic            r_carry, w_carry_n;
   logic            r_cout, w_cout_n;
   logic            r_gnt0, w_gnt0_n;
   logic            r_gnt1, w_gnt1_n;
   logic            r_busy, w_busy_n;
   logic            r_done, w_done_n;
   logic            r_done_id, w_done_id_n;
   logic            r_last_id, w_last_id_n;

   logic            w_win;
   logic [4:0]      w_nib;
   logic [W-1:0]    w_res_mrg;
   logic            w_last;

   // Tie goes to whoever was not served last; a lone request always wins.
   assign w_win     = (i_req0 & i_req1) ? ~r_last_id : i_req1;

   // Operands shift right each nibble, so the slice always sees bits [3:0].
   assign w_nib     = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_carry};
   assign w_res_mrg = W'({w_nib[3:0], r_res} >> 4);
   assign w_last    = (r_idx == IW'(NIBBLES - 1));

   always_comb begin
      w_state_n   = r_state;
      w_a_n       = r_a;
      w_b_n       = r_b;
      w_res_n     = r_res;
      w_sum_n     = r_sum;
      w_idx_n     = r_idx;
      w_carry_n   = r_carry;
      w_cout_n    = r_cout;
      w_gnt0_n    = 1'b0;
      w_gnt1_n    = 1'b0;
      w_done_n    = 1'b0;
      w_done_id_n = r_done_id;
      w_last_id_n = r_last_id;

      case (r_state)
         S_IDLE: begin
            if (i_req0 | i_req1) begin
               w_state_n   = S_ADD;
               w_last_id_n = w_win;
               w_a_n       = w_win ? i_a1 : i_a0;
               w_b_n       = w_win ? i_b1 : i_b0;
               w_carry_n   = w_win ? i_cin1 : i_cin0;
               w_idx_n     = '0;
               w_gnt0_n    = ~w_win;
               w_gnt1_n    = w_win;
            end
         end
         S_ADD: begin
            w_res_n   = w_res_mrg;
            w_carry_n = w_nib[4];
            w_a_n     = r_a >> 4;
            w_b_n     = r_b >> 4;
            w_idx_n   = r_idx + IW'(1);
            if (w_last) begin
               w_sum_n     = w_res_mrg;
               w_cout_n    = w_nib[4];
               w_done_n    = 1'b1;
               w_done_id_n = r_last_id;
               w_state_n   = S_DONE;
            end
         end
         S_DONE:  w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase

      w_busy_n = (w_state_n != S_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_res     <= '0;
         r_sum     <= '0;
         r_idx     <= '0;
         r_carry   <= 1'b0;
         r_cout    <= 1'b0;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_done_id <= 1'b0;
         r_last_id <= 1'b1;
      end else begin
         r_state   <= w_state_n;
         r_a       <= w_a_n;
         r_b       <= w_b_n;
         r_res     <= w_res_n;
         r_sum     <= w_sum_n;
         r_idx     <= w_idx_n;
         r_carry   <= w_carry_n;
         r_cout    <= w_cout_n;
         r_gnt0    <= w_gnt0_n;
         r_gnt1    <= w_gnt1_n;
         r_busy    <= w_busy_n;
         r_done    <= w_done_n;
         r_done_id <= w_done_id_n;
         r_last_id <= w_last_id_n;
      end
   end

   assign o_gnt0    = r_gnt0;
   assign o_gnt1    = r_gnt1;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_done_id = r_done_id;
   assign o_sum     = r_sum;
   assign o_cout    = r_cout;

endmodule

// File: tb/tb_nibble_serial_add_arbiter.sv
// Directed bench for nibble_serial_add_arbiter (NIBBLES=4): vector table plus
// hand-written reset, round-robin, late-request and mid-operation reset sequences.
module tb_nibble_serial_add_arbiter;

   localparam int unsigned NIB = 4;
   localparam int unsigned W   = 4 * NIB;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1;
   logic [W-1:0]  a0, b0, a1, b1;
   logic          cin0, cin1;
   logic          gnt0, gnt1, busy, done, done_id, cout;
   logic [W-1:0]  sum;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   nibble_serial_add_arbiter #(.NIBBLES(NIB)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0(req0), .i_req1(req1),
      .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1),
      .i_cin0(cin0), .i_cin1(cin1),
      .o_gnt0(gnt0), .o_gnt1(gnt1), .o_busy(busy), .o_done(done),
      .o_done_id(done_id), .o_sum(sum), .o_cout(cout)
   );

   typedef struct {
      logic         id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         co;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated operation: request, bounded wait for gnt, bounded wait for done.
   task automatic run_op(input vec_t v, input string tag);
      bit got;
      int k;
      if (v.id) begin a1 = v.a; b1 = v.b; cin1 = v.cin; req1 = 1'b1; end
      else      begin a0 = v.a; b0 = v.b; cin0 = v.cin; req0 = 1'b1; end
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (gnt0 | gnt1) begin got = 1'b1; break; end
      end
      chk({tag, " gnt seen"}, (W+1)'(got), (W+1)'(1));
      chk({tag, " gnt own"}, (W+1)'({gnt1, gnt0}), (W+1)'(v.id ? 2 : 1));
      chk({tag, " busy"}, (W+1)'(busy), (W+1)'(1));
      req0 = 1'b0;
      req1 = 1'b0;
      k = 0;
      got = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (done) begin k = i; got = 1'b1; break; end
      end
      chk({tag, " done latency"}, (W+1)'(k), (W+1)'(NIB));
      chk({tag, " sum"}, (W+1)'(sum), (W+1)'(v.s));
      chk({tag, " cout"}, (W+1)'(cout), (W+1)'(v.co));
      chk({tag, " done_id"}, (W+1)'(done_id), (W+1)'(v.id));
      tick();
      chk({tag, " done drops"}, (W+1)'(done), (W+1)'(0));
      chk({tag, " sum held"}, (W+1)'({cout, sum}), (W+1)'({v.co, v.s}));
   endtask

   initial begin
      int ngnt, ndone, prev, gcyc, dcyc;
      bit got;

      vt[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
      vt[1] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vt[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vt[3] = '{1'b1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
      vt[4] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vt[5] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vt[6] = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
      vt[7] = '{1'b1, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

      // Reset with random inputs: everything idle and zero.
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req0 = 1'($urandom); req1 = 1'($urandom);
         a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom);
         a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom);
         tick();
      end
      chk("reset flags", (W+1)'({gnt0, gnt1, busy, done, done_id, cout}), (W+1)'(0));
      chk("reset sum", (W+1)'(sum), (W+1)'(0));

      // Both requesters held from reset: 0,1,0,1 with dones 6 cycles apart.
      a0 = 16'h0001; b0 = 16'h0002; cin0 = 1'b0;
      a1 = 16'h0010; b1 = 16'h0020; cin1 = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      rst = 1'b0;
      ngnt = 0; ndone = 0; prev = 0;
      for (int c = 0; c < 60 && ndone < 4; c++) begin
         tick();
         if (gnt0 & gnt1) chk("tie gnt onehot", (W+1)'(2'b11), (W+1)'(0));
         if (gnt0 | gnt1) begin
            chk("tie gnt order", (W+1)'(gnt1), (W+1)'(ngnt % 2));
            ngnt++;
         end
         if (done) begin
            chk("tie done_id", (W+1)'(done_id), (W+1)'(ndone % 2));
            chk("tie sum", (W+1)'(sum), (W+1)'((ndone % 2) ? 16'h0030 : 16'h0003));
            if (ndone > 0) chk("tie done spacing", (W+1)'(c - prev), (W+1)'(NIB + 2));
            prev = c;
            ndone++;
         end
      end
      chk("tie done count", (W+1)'(ndone), (W+1)'(4));
      req0 = 1'b0; req1 = 1'b0;
      tick(); tick();

      foreach (vt[i]) run_op(vt[i], $sformatf("vec%0d", i));

      // Late request: req1 raised while requester 0 is being served.
      a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b0; req0 = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (gnt0) begin got = 1'b1; break; end
      end
      chk("late gnt0", (W+1)'(got), (W+1)'(1));
      req0 = 1'b0;
      tick(); tick();
      a1 = 16'h0100; b1 = 16'h0200; cin1 = 1'b1; req1 = 1'b1;
      ndone = 0; gcyc = -100; dcyc = 0;
      for (int c = 0; c < 40 && ndone < 2; c++) begin
         tick();
         if (gnt1) begin
            if (ndone == 0) chk("late gnt1 early", (W+1)'(1), (W+1)'(0));
            gcyc = c;
            req1 = 1'b0;
         end
         if (done) begin
            if (ndone == 0) begin
               chk("late first id", (W+1)'(done_id), (W+1)'(0));
               chk("late first sum", (W+1)'({cout, sum}), (W+1)'({1'b0, 16'h3333}));
               dcyc = c;
            end else begin
               chk("late second id", (W+1)'(done_id), (W+1)'(1));
               chk("late second sum", (W+1)'({cout, sum}), (W+1)'({1'b0, 16'h0301}));
            end
            ndone++;
         end
      end
      chk("late done count", (W+1)'(ndone), (W+1)'(2));
      chk("late gnt1 gap", (W+1)'(gcyc - dcyc), (W+1)'(2));
      req1 = 1'b0;
      tick(); tick();

      // Reset at E2 of an add: abandoned with no done, state back to idle.
      a0 = 16'h00FF; b0 = 16'h0001; cin0 = 1'b0; req0 = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (gnt0) begin got = 1'b1; break; end
      end
      chk("midrst gnt0", (W+1)'(got), (W+1)'(1));
      req0 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst flags", (W+1)'({busy, done, cout, gnt0, gnt1}), (W+1)'(0));
      chk("midrst sum", (W+1)'(sum), (W+1)'(0));
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done | busy) ndone++;
      end
      chk("midrst quiet", (W+1)'(ndone), (W+1)'(0));

      a0 = 16'h0F0F; b0 = 16'h00F1; cin0 = 1'b0;
      a1 = 16'h5555; b1 = 16'h5555; cin1 = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (gnt0 | gnt1) begin got = 1'b1; break; end
      end
      chk("midrst tie winner", (W+1)'({gnt1, gnt0}), (W+1)'(2'b01));
      req0 = 1'b0; req1 = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) begin got = 1'b1; break; end
      end
      chk("midrst done seen", (W+1)'(got), (W+1)'(1));
      chk("midrst result", (W+1)'({cout, sum}), (W+1)'({1'b0, 16'h1000}));
      chk("midrst done_id", (W+1)'(done_id), (W+1)'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
